img_rom_rd_arbiter: RTL and testbench

Two-port burst-read arbiter and sequencer in front of the single-port 24-bit image ROM (`blk_mem_gen_0`, 1-cycle read latency, no output register) in the HDMI erosion/dilation picture path. It shares the ROM between the display pixel fetcher (port 0) and the morphology line fetcher (port 1). Arbitration is round-robin at burst granularity. For each granted burst the block drives sequential ROM addresses and returns registered read data tagged with requester id and a last flag.

---
 rtl/img_rom_rd_if.sv | 55 +++++
 rtl/img_rom_rd_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_img_rom_rd_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_rom_rd_if.sv
// ---------------------------------------------------------------------------
// img_rom_rd_if
//
// Bundles every signal between the image-ROM read arbiter and its two
// requesters, the ROM itself, and the read-data consumer.
//
//   req0/req1      burst request, level           (requester -> arbiter)
//   addr0/addr1    burst start address            (requester -> arbiter)
//   len0/len1      burst word count               (requester -> arbiter)
//   gnt0/gnt1      one-cycle accept pulse         (arbiter -> requester)
//   rom_addr       ROM address                    (arbiter -> ROM)
//   rom_rd_data    ROM read word, 1-cycle latency (ROM -> arbiter)
//   out_data       registered read word           (arbiter -> consumer)
//   out_valid      out_data qualifier
//   out_id         requester that owns out_data
//   out_last       final word of a burst
//   busy           arbiter is issuing a burst
//
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system's view (requesters, ROM, consumer)
// ---------------------------------------------------------------------------
interface img_rom_rd_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int LEN_WIDTH  = 12
) ();

  logic                  req0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [LEN_WIDTH-1:0]  len0;
  logic [LEN_WIDTH-1:0]  len1;
  logic                  gnt0;
  logic                  gnt1;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_id;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, rom_rd_data,
    output gnt0, gnt1, rom_addr, out_data, out_valid, out_id, out_last, busy
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, rom_rd_data,
    input  gnt0, gnt1, rom_addr, out_data, out_valid, out_id, out_last, busy
  );

endinterface

// File: rtl/img_rom_rd_arbiter.sv
// ---------------------------------------------------------------------------
// img_rom_rd_arbiter
//
// Shares the single-port image ROM (1-cycle read latency, no output
// register) between the display pixel fetcher (port 0) and the morphology
// line fetcher (port 1). Requests are arbitrated round-robin at burst
// granularity; a granted burst is issued as consecutive ROM addresses, one
// per cycle, and the returned words are registered and tagged with the
// owning requester id and an end-of-burst flag.
//
// Ports:
//   clk     system clock, shared with the ROM
//   tb_rst  asynchronous, active-high reset
//   bus     img_rom_rd_if.slave: request/grant, ROM address/data, output
//           stream and busy (see the interface header for the signal list)
//
// Timing summary (E = edge that accepts a request):
//   gnt, busy and the first rom_addr appear in cycle E+1, issue runs for
//   len cycles, out_valid follows each issue by 2 cycles. One idle cycle
//   separates consecutive bursts. A zero-length request is acknowledged
//   with gnt but issues nothing and leaves the FSM in IDLE.
// ---------------------------------------------------------------------------
module img_rom_rd_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int LEN_WIDTH  = 12
) (
  input  logic           clk,
  input  logic           tb_rst,
  img_rom_rd_if.slave    bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                state;
  logic                  last_served;  // port granted most recently
  logic                  cur_id;       // owner of the burst being issued
  logic [ADDR_WIDTH-1:0] cur_addr;     // address issued this cycle; is rom_addr
  logic [LEN_WIDTH-1:0]  cur_cnt;      // issues left, including this cycle

  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  busy_q;

  // Return pipeline: stage 1 lines up with rom_rd_data, stage 2 is the
  // registered output.
  logic                  s1_valid;
  logic                  s1_id;
  logic                  s1_last;

  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_id_q;
  logic                  out_last_q;

  // -------------------------------------------------------------------------
  // Winner selection (only consumed in IDLE)
  // -------------------------------------------------------------------------
  logic                  any_req;
  logic                  win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]  win_len;

  // NOTE: every output of a combinational block is given a default at the
  // top so no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    any_req  = 1'b0;
    win_id   = 1'b0;
    win_addr = bus.addr0;
    win_len  = bus.len0;

    any_req = bus.req0 | bus.req1;

    // On a tie the port that was not served last wins; otherwise the sole
    // requester wins.
    if (bus.req0 && bus.req1) begin
      win_id = ~last_served;
    end else begin
      win_id = bus.req1;
    end

    if (win_id) begin
      win_addr = bus.addr1;
      win_len  = bus.len1;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration / issue FSM
  // -------------------------------------------------------------------------
  // NOTE: all sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values of the others, independent of
  // statement order.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state       <= IDLE;
      last_served <= 1'b1;   // port 0 wins the first tie
      cur_id      <= 1'b0;
      cur_addr    <= '0;
      cur_cnt     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            gnt0_q      <= ~win_id;
            gnt1_q      <= win_id;
            last_served <= win_id;
            cur_id      <= win_id;
            cur_cnt     <= win_len;
            // cur_addr doubles as rom_addr, so it is only loaded when a read
            // will actually be issued; a zero-length grant leaves the ROM
            // address untouched.
            if (win_len != '0) begin
              cur_addr <= win_addr;
              state    <= BURST;
              busy_q   <= 1'b1;
            end
          end
        end

        BURST: begin
          cur_cnt <= cur_cnt - LEN_WIDTH'(1);
          if (cur_cnt == LEN_WIDTH'(1)) begin
            // Last issue: hold the final address on rom_addr while idle.
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cur_addr <= cur_addr + ADDR_WIDTH'(1);  // wraps at the top
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Return pipeline
  // -------------------------------------------------------------------------
  // NOTE: the data register is reset along with the flags so the output is
  // a known value out of reset; flags must reset so in-flight words from an
  // aborted burst are dropped.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      s1_valid    <= 1'b0;
      s1_id       <= 1'b0;
      s1_last     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      s1_valid <= (state == BURST);
      s1_id    <= cur_id;
      s1_last  <= (state == BURST) && (cur_cnt == LEN_WIDTH'(1));

      out_valid_q <= s1_valid;
      out_last_q  <= s1_last;
      // Data and id hold between bursts instead of tracking idle ROM reads.
      if (s1_valid) begin
        out_data_q <= bus.rom_rd_data;
        out_id_q   <= s1_id;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.busy      = busy_q;
  assign bus.rom_addr  = cur_addr;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_img_rom_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_img_rom_rd_arbiter
//
// Drives the arbiter with directed and randomized burst requests and checks
// every cycle against a timestamp-based reference model: each accepted
// request is turned into expected grant/issue/return events keyed by cycle
// number, computed from the arbitration rules with plain arithmetic.
// ROM model: rd_data = {8'hA5, addr} one cycle after addr.
// ---------------------------------------------------------------------------
module tb_img_rom_rd_arbiter;

  localparam int AW = 16;
  localparam int DW = 24;
  localparam int LW = 12;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          id;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic tb_rst;

  img_rom_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  img_rom_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk    (clk),
    .tb_rst (tb_rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ROM: one-cycle read latency
  always @(posedge clk) bus.rom_rd_data <= {8'hA5, bus.rom_addr};

  // ---------------------------------------------------------------------------
  // Bookkeeping and reference model state
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit            exp_gnt0 [int];
  bit            exp_gnt1 [int];
  bit            exp_busy [int];
  logic [AW-1:0] exp_rom  [int];
  beat_t         exp_beat [int];

  logic [AW-1:0] rom_hold;
  int            idle_at;
  bit            last_served;

  bit auto_en;
  int fixed_len;
  int fixed_gap;
  int gap [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input int l);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.addr0 = a; bus.len0 = LW'(l);
    end else begin
      bus.req1 = 1'b1; bus.addr1 = a; bus.len1 = LW'(l);
    end
  endtask

  task automatic model_clear();
    exp_gnt0.delete();
    exp_gnt1.delete();
    exp_busy.delete();
    exp_rom.delete();
    exp_beat.delete();
    rom_hold    = '0;
    last_served = 1'b1;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
  endtask

  // Called just before the edge that ends cycle 'cyc', with the request
  // inputs as the DUT will sample them.
  task automatic model_eval();
    bit            w;
    logic [AW-1:0] a;
    int            l;
    logic [AW-1:0] ak;
    beat_t         b;
    if (!tb_rst && cyc >= idle_at && (bus.req0 || bus.req1)) begin
      w = (bus.req0 && bus.req1) ? !last_served : bus.req1;
      a = w ? bus.addr1 : bus.addr0;
      l = int'(w ? bus.len1 : bus.len0);
      if (w) exp_gnt1[cyc+1] = 1'b1;
      else   exp_gnt0[cyc+1] = 1'b1;
      for (int k = 0; k < l; k++) begin
        ak = AW'((int'(a) + k) % (1 << AW));
        exp_rom[cyc+1+k]  = ak;
        exp_busy[cyc+1+k] = 1'b1;
        b.data = {8'hA5, ak};
        b.id   = w;
        b.last = (k == l - 1);
        exp_beat[cyc+3+k] = b;
      end
      idle_at     = cyc + 1 + l;
      last_served = w;
    end
  endtask

  // Mid-cycle: compare all outputs for the current cycle, then withdraw any
  // request that the model says is being granted now.
  task automatic sample();
    beat_t b;
    @(negedge clk);
    check("gnt0", 32'(bus.gnt0), 32'(exp_gnt0.exists(cyc)));
    check("gnt1", 32'(bus.gnt1), 32'(exp_gnt1.exists(cyc)));
    check("busy", 32'(bus.busy), 32'(exp_busy.exists(cyc)));
    if (exp_rom.exists(cyc)) rom_hold = exp_rom[cyc];
    check("rom_addr", 32'(bus.rom_addr), 32'(rom_hold));
    if (exp_beat.exists(cyc)) begin
      b = exp_beat[cyc];
      check("out_valid", 32'(bus.out_valid), 32'(1));
      check("out_data", 32'(bus.out_data), 32'(b.data));
      check("out_id", 32'(bus.out_id), 32'(b.id));
      check("out_last", 32'(bus.out_last), 32'(b.last));
    end else begin
      check("out_valid", 32'(bus.out_valid), 32'(0));
    end
    if (exp_gnt0.exists(cyc)) begin
      bus.req0 = 1'b0;
      gap[0] = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(1, 4));
    end
    if (exp_gnt1.exists(cyc)) begin
      bus.req1 = 1'b0;
      gap[1] = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(1, 4));
    end
  endtask

  task automatic drive_auto();
    logic [AW-1:0] a;
    int            l;
    bit            active;
    for (int p = 0; p < 2; p++) begin
      active = (p == 0) ? bus.req0 : bus.req1;
      if (!active) begin
        if (gap[p] == 0) begin
          a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(16'hFFF0, 16'hFFFF))
                                          : AW'($urandom());
          if (fixed_len >= 0)                l = fixed_len;
          else if ($urandom_range(0, 9) == 0) l = 0;
          else if ($urandom_range(0, 7) == 0) l = int'($urandom_range(10, 40));
          else                               l = int'($urandom_range(1, 9));
          set_req(p, a, l);
        end else begin
          gap[p]--;
        end
      end
    end
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      if (auto_en) drive_auto();
      advance();
    end
  endtask

  // Called just after a rising edge: assert reset asynchronously mid-cycle,
  // check that outputs drop at once, hold for two cycles and release.
  task automatic reset_pulse();
    #2 tb_rst = 1'b1;
    model_clear();
    #1;
    check("rst_gnt0", 32'(bus.gnt0), 32'(0));
    check("rst_gnt1", 32'(bus.gnt1), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_last", 32'(bus.out_last), 32'(0));
    check("rst_out_id", 32'(bus.out_id), 32'(0));
    check("rst_out_data", 32'(bus.out_data), 32'(0));
    check("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
    sample();
    advance();
    sample();
    tb_rst  = 1'b0;
    idle_at = cyc;
    advance();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    tb_rst    = 1'b1;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.len0  = '0;
    bus.len1  = '0;
    auto_en   = 1'b0;
    fixed_len = -1;
    fixed_gap = -1;
    gap[0]    = 0;
    gap[1]    = 0;
    idle_at   = 0;
    model_clear();

    @(posedge clk);
    reset_pulse();

    // Single burst on port 0
    sample(); set_req(0, 16'h0010, 4); advance();
    run(10);

    // Tie right after reset: port 0 first, then port 1
    reset_pulse();
    sample(); set_req(0, 16'h0100, 2); set_req(1, 16'h0200, 2); advance();
    run(12);

    // Persistent contention, len 3 each: grants alternate
    auto_en = 1'b1; fixed_len = 3; fixed_gap = 1; gap[0] = 0; gap[1] = 0;
    run(17);
    auto_en = 1'b0;
    run(14);

    // Address wrap on port 1
    sample(); set_req(1, 16'hFFFE, 4); advance();
    run(10);

    // Zero-length request on port 0 with port 1 pending
    reset_pulse();
    sample(); set_req(0, 16'h1234, 0); set_req(1, 16'h0400, 2); advance();
    run(8);

    // Reset during the 3rd issue of a len-8 burst, then a clean burst
    sample(); set_req(0, 16'h0200, 8); advance();
    sample(); advance();
    sample(); advance();
    reset_pulse();
    sample(); set_req(0, 16'h0300, 3); advance();
    run(10);

    // Randomized traffic
    fixed_len = -1; fixed_gap = -1; gap[0] = 0; gap[1] = 0;
    auto_en = 1'b1;
    run(3000);
    auto_en = 1'b0;
    run(120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
